// File: rtl/matmul_engine_if.sv
// Start/status handshake plus A/B read-select and C write ports of matmul_engine.
// The slave modport is the engine; master is the side that owns the matrix storage.
interface matmul_engine_if #(
    parameter int DW = 8
);
    // start is a single-cycle request. It is honoured only while busy=0 and ignored otherwise.
    // C entries are committed on every rising edge where cWriteEn=1.
    logic          start;
    logic          busy;
    logic          done;
    logic [DW-1:0] aRowSel;
    logic [DW-1:0] aColSel;
    logic [DW-1:0] aData;
    logic [DW-1:0] bRowSel;
    logic [DW-1:0] bColSel;
    logic [DW-1:0] bData;
    logic [DW-1:0] cRowSel;
    logic [DW-1:0] cColSel;
    logic          cWriteEn;
    logic [DW-1:0] cData;

    modport master (
        output start, aData, bData,
        input  busy, done, aRowSel, aColSel, bRowSel, bColSel,
        input  cRowSel, cColSel, cWriteEn, cData
    );

    modport slave (
        input  start, aData, bData,
        output busy, done, aRowSel, aColSel, bRowSel, bColSel,
        output cRowSel, cColSel, cWriteEn, cData
    );
endinterface

// File: rtl/matmul_engine.sv
// Sequential C = A x B engine: one multiply-accumulate per cycle, then one C write per element.
// Optional macro MATMUL_SAT_EN clamps each C element to 2^DW-1 instead of wrapping it.
module matmul_engine #(
    parameter int M  = 2,
    parameter int N  = 2,
    parameter int P  = 2,
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    matmul_engine_if.slave     mm,
    output logic [1:0]         o_dbg_state
);
    // Sized so that N full-scale products can be summed without wrapping.
    localparam int AW = 2*DW + $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_i;
    logic [DW-1:0]   r_j;
    logic [DW-1:0]   r_k;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   w_prod;
    logic [DW-1:0]   w_result;
    logic            w_in_mac;
    logic            w_in_write;

    assign w_prod = AW'(mm.aData) * AW'(mm.bData);

`ifdef MATMUL_SAT_EN
    assign w_result = (r_acc > AW'({DW{1'b1}})) ? {DW{1'b1}} : r_acc[DW-1:0];
`else
    assign w_result = r_acc[DW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mm.start) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod;
                    if (r_k == DW'(N-1)) begin
                        r_k     <= '0;
                        r_state <= WRITE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                WRITE: begin
                    r_acc <= '0;
                    if (r_j == DW'(P-1)) begin
                        r_j <= '0;
                        if (r_i == DW'(M-1)) begin
                            r_i     <= '0;
                            r_state <= DONE;
                        end else begin
                            r_i     <= r_i + 1'b1;
                            r_state <= MAC;
                        end
                    end else begin
                        r_j     <= r_j + 1'b1;
                        r_state <= MAC;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Every output is a decode of flops only, so selects are stable for the whole cycle.
    assign w_in_mac   = (r_state == MAC);
    assign w_in_write = (r_state == WRITE);

    assign mm.busy     = (r_state != IDLE);
    assign mm.done     = (r_state == DONE);
    assign mm.aRowSel  = w_in_mac ? r_i : '0;
    assign mm.aColSel  = w_in_mac ? r_k : '0;
    assign mm.bRowSel  = w_in_mac ? r_k : '0;
    assign mm.bColSel  = w_in_mac ? r_j : '0;
    assign mm.cRowSel  = w_in_write ? r_i : '0;
    assign mm.cColSel  = w_in_write ? r_j : '0;
    assign mm.cWriteEn = w_in_write;
    assign mm.cData    = w_in_write ? w_result : '0;
    assign o_dbg_state = r_state;
endmodule
